// File: rtl/bch_pkg.sv
// Shared constants and FSM state type for the BCH decoder pattern player.
package bch_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int ODATA_W_DEF = 10;

    localparam logic [1:0] CODE_63   = 2'd1;
    localparam logic [1:0] CODE_255  = 2'd2;
    localparam logic [1:0] CODE_1023 = 2'd3;

    localparam logic MODE_HARD = 1'b0;
    localparam logic MODE_SOFT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        RUN,
        GAP,
        DONE
    } pp_state_t;

endpackage

// File: rtl/bch_pp_checker.sv
// Result checker: compares each finish-cycle result against golden data,
// counts compares and mismatches, and captures the first mismatch.
module bch_pp_checker
    import bch_pkg::*;
#(
    parameter int ODATA_W = ODATA_W_DEF,
    parameter int IDX_W   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               finish,
    input  logic [ODATA_W-1:0] got,
    input  logic [ODATA_W-1:0] exp,
    output logic [15:0]        err_cnt,
    output logic [IDX_W-1:0]   cmp_cnt,
    output logic               fail_valid,
    output logic [IDX_W-1:0]   fail_idx,
    output logic [ODATA_W-1:0] fail_got,
    output logic [ODATA_W-1:0] fail_exp
);

    logic hit;
    logic miss;

    assign hit  = en & finish;
    assign miss = hit & (got != exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt    <= '0;
            cmp_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else if (clr) begin
            err_cnt    <= '0;
            cmp_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            fail_got   <= '0;
            fail_exp   <= '0;
        end else begin
            if (hit)
                cmp_cnt <= cmp_cnt + 1'b1;
            if (miss && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 1'b1;
            // cmp_cnt is the index of the result being compared this cycle
            if (miss && !fail_valid) begin
                fail_valid <= 1'b1;
                fail_idx   <= cmp_cnt;
                fail_got   <= got;
                fail_exp   <= exp;
            end
        end
    end

endmodule

// File: rtl/bch_pattern_player.sv
// Pattern player for the BCH decoder: sequences set/run/gap per decode,
// streams stimulus words on ready and checks results against golden memory.
module bch_pattern_player
    import bch_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ODATA_W = ODATA_W_DEF,
    parameter int SADDR_W = 21,
    parameter int GADDR_W = 17,
    parameter int TEST_W  = 16,
    parameter int TMO_W   = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic [1:0]         cfg_code,
    input  logic [TEST_W-1:0]  cfg_ntest,
    input  logic [7:0]         cfg_gap,
    input  logic [TMO_W-1:0]   cfg_timeout,
    output logic [SADDR_W-1:0] stim_addr,
    input  logic [DATA_W-1:0]  stim_data,
    output logic [GADDR_W-1:0] gold_addr,
    input  logic [ODATA_W-1:0] gold_data,
    output logic               dut_set,
    output logic               dut_mode,
    output logic [1:0]         dut_code,
    output logic [DATA_W-1:0]  dut_idata,
    input  logic               dut_ready,
    input  logic               dut_finish,
    input  logic [ODATA_W-1:0] dut_odata,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [15:0]        err_cnt,
    output logic [GADDR_W-1:0] cmp_cnt,
    output logic               fail_valid,
    output logic [GADDR_W-1:0] fail_idx,
    output logic [ODATA_W-1:0] fail_got,
    output logic [ODATA_W-1:0] fail_exp
);

    pp_state_t          state, state_nxt;
    logic               mode_lat;
    logic [1:0]         code_lat;
    logic [TEST_W-1:0]  ntest_lat;
    logic [7:0]         gap_lat;
    logic [TMO_W-1:0]   tmo_lat;
    logic [SADDR_W-1:0] stim_ptr;
    logic [TEST_W-1:0]  test_idx;
    logic [7:0]         gap_cnt;
    logic [TMO_W-1:0]   wdog;
    logic               timeout_q;

    logic               start_ok;
    logic               more_tests;
    logic               tmo_hit;
    logic               test_end;
    logic [TEST_W:0]    idx_inc;
    logic [TMO_W:0]     wdog_ahead;

    assign start_ok   = start & ((state == IDLE) | (state == DONE));
    assign idx_inc    = {1'b0, test_idx} + (TEST_W+1)'(1);
    assign more_tests = idx_inc < {1'b0, ntest_lat};
    // Fire one cycle early so done lands exactly cfg_timeout cycles after set
    assign wdog_ahead = {1'b0, wdog} + (TMO_W+1)'(2);
    assign tmo_hit    = wdog_ahead >= {1'b0, tmo_lat};
    assign test_end   = ((state == RUN) & dut_finish & (gap_lat == 8'd0)) |
                        ((state == GAP) & (gap_cnt == 8'd1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start)
                    state_nxt = (cfg_ntest == '0) ? DONE : SET;
            end
            SET: state_nxt = RUN;
            RUN: begin
                if (dut_finish) begin
                    if (gap_lat != 8'd0)
                        state_nxt = GAP;
                    else
                        state_nxt = more_tests ? SET : DONE;
                end else if (tmo_hit) begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd1)
                    state_nxt = more_tests ? SET : DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_lat  <= 1'b0;
            code_lat  <= '0;
            ntest_lat <= '0;
            gap_lat   <= '0;
            tmo_lat   <= '0;
            stim_ptr  <= '0;
            test_idx  <= '0;
            gap_cnt   <= '0;
            wdog      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start_ok) begin
                mode_lat  <= cfg_mode;
                code_lat  <= cfg_code;
                ntest_lat <= cfg_ntest;
                gap_lat   <= cfg_gap;
                tmo_lat   <= cfg_timeout;
                stim_ptr  <= '0;
                test_idx  <= '0;
                timeout_q <= 1'b0;
            end else if (busy && dut_ready) begin
                stim_ptr <= stim_ptr + 1'b1;
            end

            if (state == SET)
                wdog <= '0;
            else if (state == RUN)
                wdog <= wdog + 1'b1;

            if ((state == RUN) && !dut_finish && tmo_hit)
                timeout_q <= 1'b1;

            if ((state == RUN) && dut_finish)
                gap_cnt <= gap_lat;
            else if (state == GAP)
                gap_cnt <= gap_cnt - 1'b1;

            if (test_end)
                test_idx <= idx_inc[TEST_W-1:0];
        end
    end

    // Result pointer and compare count advance together, so one register serves both
    bch_pp_checker #(
        .ODATA_W (ODATA_W),
        .IDX_W   (GADDR_W)
    ) u_checker (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .en         ((state == RUN) || (state == GAP)),
        .finish     (dut_finish),
        .got        (dut_odata),
        .exp        (gold_data),
        .err_cnt    (err_cnt),
        .cmp_cnt    (cmp_cnt),
        .fail_valid (fail_valid),
        .fail_idx   (fail_idx),
        .fail_got   (fail_got),
        .fail_exp   (fail_exp)
    );

    assign stim_addr = stim_ptr;
    assign dut_idata = stim_data;
    assign gold_addr = cmp_cnt;
    assign dut_set   = (state == SET);
    assign dut_mode  = (state != IDLE) & mode_lat;
    assign dut_code  = (state != IDLE) ? code_lat : 2'd0;
    assign busy      = (state == SET) | (state == RUN) | (state == GAP);
    assign done      = (state == DONE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bch_pattern_player.sv
// Directed bench for bch_pattern_player with a behavioural decoder model
// and address-derived stimulus/golden memories.
module tb_bch_pattern_player;
    import bch_pkg::*;

    localparam int DATA_W  = 64;
    localparam int ODATA_W = 10;
    localparam int SADDR_W = 21;
    localparam int GADDR_W = 17;
    localparam int TEST_W  = 16;
    localparam int TMO_W   = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               cfg_mode;
    logic [1:0]         cfg_code;
    logic [TEST_W-1:0]  cfg_ntest;
    logic [7:0]         cfg_gap;
    logic [TMO_W-1:0]   cfg_timeout;
    logic [SADDR_W-1:0] stim_addr;
    logic [DATA_W-1:0]  stim_data;
    logic [GADDR_W-1:0] gold_addr;
    logic [ODATA_W-1:0] gold_data;
    logic               dut_set, dut_mode;
    logic [1:0]         dut_code;
    logic [DATA_W-1:0]  dut_idata;
    logic               dut_ready;
    logic               dut_finish;
    logic [ODATA_W-1:0] dut_odata;
    logic               busy, done, timeout;
    logic [15:0]        err_cnt;
    logic [GADDR_W-1:0] cmp_cnt;
    logic               fail_valid;
    logic [GADDR_W-1:0] fail_idx;
    logic [ODATA_W-1:0] fail_got, fail_exp;

    int n_chk  = 0;
    int n_fail = 0;

    // decoder model controls and monitor counters
    int   m_lat     = 5;
    int   m_nfin    = 1;
    bit   m_fin_en  = 1'b1;
    int   m_corrupt = -1;
    int   lat_left  = 0;
    int   fin_left  = 0;
    int   model_res = 0;
    int   set_cnt   = 0;
    int   set_wide  = 0;
    logic prev_set  = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] stim_word(input logic [SADDR_W-1:0] a);
        return {11'h5A5, a, 11'h3C3, a};
    endfunction

    function automatic logic [ODATA_W-1:0] gold_word(input logic [3:0] i);
        logic [ODATA_W-1:0] v;
        v = 10'(i) * 10'd37 + 10'd3;
        if (i == 4'd5)
            v = 10'h0AA;
        return v;
    endfunction

    assign stim_data = stim_word(stim_addr);
    assign gold_data = gold_word(gold_addr[3:0]);

    bch_pattern_player #(
        .DATA_W  (DATA_W),
        .ODATA_W (ODATA_W),
        .SADDR_W (SADDR_W),
        .GADDR_W (GADDR_W),
        .TEST_W  (TEST_W),
        .TMO_W   (TMO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_mode    (cfg_mode),
        .cfg_code    (cfg_code),
        .cfg_ntest   (cfg_ntest),
        .cfg_gap     (cfg_gap),
        .cfg_timeout (cfg_timeout),
        .stim_addr   (stim_addr),
        .stim_data   (stim_data),
        .gold_addr   (gold_addr),
        .gold_data   (gold_data),
        .dut_set     (dut_set),
        .dut_mode    (dut_mode),
        .dut_code    (dut_code),
        .dut_idata   (dut_idata),
        .dut_ready   (dut_ready),
        .dut_finish  (dut_finish),
        .dut_odata   (dut_odata),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .err_cnt     (err_cnt),
        .cmp_cnt     (cmp_cnt),
        .fail_valid  (fail_valid),
        .fail_idx    (fail_idx),
        .fail_got    (fail_got),
        .fail_exp    (fail_exp)
    );

    // Decoder model: first finish m_lat cycles after set, m_nfin cycles wide
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            lat_left   = 0;
            fin_left   = 0;
            dut_finish = 1'b0;
            dut_odata  = '0;
            prev_set   = 1'b0;
        end else begin
            if (start) begin
                set_cnt   = 0;
                set_wide  = 0;
                model_res = 0;
            end
            if (dut_set) begin
                set_cnt++;
                if (prev_set)
                    set_wide++;
            end
            prev_set   = dut_set;
            dut_finish = 1'b0;
            if (dut_set) begin
                lat_left = m_lat;
            end else if (lat_left > 0) begin
                lat_left--;
                if (lat_left == 0 && m_fin_en)
                    fin_left = m_nfin;
            end
            if (fin_left > 0) begin
                dut_finish = 1'b1;
                dut_odata  = (model_res == m_corrupt) ? 10'h155 : gold_word(4'(model_res));
                model_res++;
                fin_left--;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic mode, input logic [1:0] code,
                            input int ntest, input int gap, input int tmo);
        cfg_mode    = mode;
        cfg_code    = code;
        cfg_ntest   = TEST_W'(ntest);
        cfg_gap     = 8'(gap);
        cfg_timeout = TMO_W'(tmo);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(output int n, input int limit);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        logic [115:0] outs;
        outs = {dut_set, dut_mode, dut_code, busy, done, timeout, fail_valid, err_cnt,
                cmp_cnt, stim_addr, gold_addr, fail_idx, fail_got, fail_exp};
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if ({busy, done, dut_set} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: busy/done/set got %b expected 000", {busy, done, dut_set});
        end
    endtask

    task automatic test_basic;
        int n;
        m_lat = 5; m_nfin = 1; m_fin_en = 1'b1; m_corrupt = -1;
        do_start(MODE_HARD, CODE_63, 4, 10, 1000);
        n_chk++;
        if ({dut_set, dut_mode, dut_code} !== {1'b1, MODE_HARD, CODE_63}) begin
            n_fail++;
            $display("FAIL basic_first_set: set/mode/code got %b expected 1001", {dut_set, dut_mode, dut_code});
        end
        wait_done(n, 500);
        n_chk++;
        if (n !== 64) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d expected 64", n);
        end
        n_chk++;
        if ({done, busy, timeout, fail_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_status: done/busy/timeout/fail_valid got %b expected 1000", {done, busy, timeout, fail_valid});
        end
        n_chk++;
        if (err_cnt !== 16'd0 || cmp_cnt !== 17'd4) begin
            n_fail++;
            $display("FAIL basic_counts: err %0d cmp %0d expected 0 4", err_cnt, cmp_cnt);
        end
        n_chk++;
        if (set_cnt !== 4 || set_wide !== 0) begin
            n_fail++;
            $display("FAIL basic_set_pulses: count %0d wide %0d expected 4 0", set_cnt, set_wide);
        end
    endtask

    task automatic test_soft_multi;
        int n;
        m_lat = 4; m_nfin = 3; m_fin_en = 1'b1; m_corrupt = -1;
        do_start(MODE_SOFT, CODE_1023, 2, 4, 1000);
        n_chk++;
        if ({dut_mode, dut_code} !== {MODE_SOFT, CODE_1023}) begin
            n_fail++;
            $display("FAIL soft_mode_code: got %b expected 111", {dut_mode, dut_code});
        end
        wait_done(n, 500);
        n_chk++;
        if (n !== 18) begin
            n_fail++;
            $display("FAIL soft_done_cycle: got %0d expected 18", n);
        end
        n_chk++;
        if (cmp_cnt !== 17'd6 || gold_addr !== 17'd6 || err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL soft_counts: cmp %0d gold_addr %0d err %0d expected 6 6 0", cmp_cnt, gold_addr, err_cnt);
        end
    endtask

    task automatic test_mismatch;
        int n;
        m_lat = 3; m_nfin = 1; m_fin_en = 1'b1; m_corrupt = 5;
        do_start(MODE_HARD, CODE_63, 6, 1, 1000);
        wait_done(n, 500);
        n_chk++;
        if (err_cnt !== 16'd1 || cmp_cnt !== 17'd6 || fail_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch_counts: err %0d cmp %0d valid %b expected 1 6 1", err_cnt, cmp_cnt, fail_valid);
        end
        n_chk++;
        if (fail_idx !== 17'd5 || fail_got !== 10'h155 || fail_exp !== 10'h0AA) begin
            n_fail++;
            $display("FAIL mismatch_capture: idx %0d got %h exp %h expected 5 155 0aa", fail_idx, fail_got, fail_exp);
        end
        m_corrupt = -1;
    endtask

    task automatic test_timeout;
        int n;
        m_fin_en = 1'b0;
        do_start(MODE_HARD, CODE_255, 1, 3, 100);
        wait_done(n, 500);
        n_chk++;
        if (n !== 100) begin
            n_fail++;
            $display("FAIL timeout_cycle: got %0d expected 100", n);
        end
        n_chk++;
        if ({timeout, done, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_status: timeout/done/busy got %b expected 110", {timeout, done, busy});
        end
        n_chk++;
        if (err_cnt !== 16'd0 || fail_valid !== 1'b0 || cmp_cnt !== 17'd0) begin
            n_fail++;
            $display("FAIL timeout_cleared: err %0d valid %b cmp %0d expected 0 0 0", err_cnt, fail_valid, cmp_cnt);
        end
    endtask

    task automatic test_stream;
        m_fin_en = 1'b0;
        do_start(MODE_HARD, CODE_63, 1, 0, 5000);
        for (int k = 0; k < 11; k++) begin
            if (k >= 8) begin
                dut_ready = 1'b0;
                tick();
            end
            dut_ready = 1'b1;
            n_chk++;
            if (dut_idata !== stim_word(SADDR_W'(k))) begin
                n_fail++;
                $display("FAIL stream_word_%0d: got %h expected %h", k, dut_idata, stim_word(SADDR_W'(k)));
            end
            tick();
        end
        dut_ready = 1'b0;
        tick();
        tick();
        n_chk++;
        if (stim_addr !== 21'd11) begin
            n_fail++;
            $display("FAIL stream_advance: got %0d expected 11", stim_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_abort_and_zero;
        logic [115:0] outs;
        m_lat = 3; m_nfin = 1; m_fin_en = 1'b1; m_corrupt = -1;
        dut_ready = 1'b1;
        do_start(MODE_SOFT, CODE_63, 3, 5, 1000);
        for (int i = 0; i < 5; i++)
            tick();
        cfg_ntest = '0;
        cfg_code  = CODE_1023;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        n_chk++;
        if ({busy, done, dut_code} !== {1'b1, 1'b0, CODE_63} || cmp_cnt !== 17'd1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: busy/done/code %b cmp %0d expected 1001 1", {busy, done, dut_code}, cmp_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        outs = {dut_set, dut_mode, dut_code, busy, done, timeout, fail_valid, err_cnt,
                cmp_cnt, stim_addr, gold_addr, fail_idx, fail_got, fail_exp};
        n_chk++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %h expected 0", outs);
        end
        dut_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        do_start(MODE_HARD, CODE_1023, 0, 5, 1000);
        n_chk++;
        if ({done, busy, dut_set} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_ntest_done: done/busy/set got %b expected 100", {done, busy, dut_set});
        end
        tick();
        tick();
        tick();
        n_chk++;
        if (set_cnt !== 0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ntest_hold: sets %0d done %b expected 0 1", set_cnt, done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_mode    = 1'b0;
        cfg_code    = '0;
        cfg_ntest   = '0;
        cfg_gap     = '0;
        cfg_timeout = '0;
        dut_ready   = 1'b0;
        #1;
        tick();
        test_reset();
        test_basic();
        test_soft_multi();
        test_mismatch();
        test_timeout();
        test_stream();
        test_abort_and_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bch_pattern_player.md
# bch_pattern_player

Synthesizable, parametrised stimulus player and response checker for the `bch` decoder interface. It runs a configurable number of decodes back to back:
- issues `set` with `mode`/`code` for each decode;
- streams stimulus words from an external stimulus memory on every DUT `ready`;
- compares every `finish` cycle's `odata` against a golden memory;
- reports an error count, first-failure capture and a watchdog timeout.

It sits between on-chip pattern ROMs and the decoder for BIST and FPGA bring-up.

## Interface
Parameters:
- DATA_W, 64, DUT `idata` width
- ODATA_W, 10, DUT `odata` width
- SADDR_W, 21, stimulus memory address width
- GADDR_W, 17, golden memory address width
- TEST_W, 16, width of the test count and test index
- TMO_W, 24, watchdog counter width

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- cfg_mode  in  1  0 = hard decision, 1 = soft decision
- cfg_code  in  2  1 = BCH63, 2 = BCH255, 3 = BCH1023
- cfg_ntest  in  TEST_W  number of decodes; 0 = none
- cfg_gap  in  8  idle cycles after the first `finish` of each decode
- cfg_timeout  in  TMO_W  maximum cycles from `set` to the first `finish`
- stim_addr  out  SADDR_W  stimulus read address
- stim_data  in  DATA_W  combinational read data of stim_addr
- gold_addr  out  GADDR_W  golden read address
- gold_data  in  ODATA_W  combinational read data of gold_addr
- dut_set, dut_mode  out  1  DUT controls
- dut_code  out  2  DUT code select
- dut_idata  out  DATA_W  equals stim_data
- dut_ready, dut_finish  in  1  DUT status
- dut_odata  in  ODATA_W  DUT result
- busy, done, timeout  out  1  run status
- err_cnt  out  16  saturating mismatch count
- cmp_cnt  out  GADDR_W  number of compares performed
- fail_valid  out  1  a mismatch has been captured
- fail_idx  out  GADDR_W  result index of the first mismatch
- fail_got, fail_exp  out  ODATA_W  DUT value and golden value at the first mismatch

## Operation
- FSM states: IDLE, SET, RUN, GAP, DONE.
- IDLE:
  - `start` latches all cfg_* inputs.
  - Clears the stimulus pointer, result pointer, err_cnt, cmp_cnt, fail_*, timeout and done.
  - Goes to SET, or straight to DONE if cfg_ntest = 0.
- SET: dut_set = 1 for exactly one cycle; goes to RUN; the watchdog is cleared.
- RUN:
  - The watchdog increments every cycle.
  - On the first dut_finish, go to GAP.
  - If the watchdog reaches cfg_timeout, set timeout and go to DONE.
- GAP:
  - Counts cfg_gap cycles.
  - Then the test index increments; go to SET if index < cfg_ntest, otherwise DONE.
- DONE: done = 1 and holds; `start` begins a new run.
- Stimulus streaming:
  - stim_addr = stimulus pointer; dut_idata = stim_data.
  - In SET, RUN or GAP, each cycle with dut_ready = 1 advances the pointer by 1.
  - The pointer never resets between decodes within a run.
- Checking:
  - gold_addr = result pointer.
  - In RUN or GAP, each cycle with dut_finish = 1 compares dut_odata to gold_data, then increments the result pointer and cmp_cnt.
  - A mismatch increments err_cnt, which saturates at 0xFFFF.
  - The first mismatch sets fail_valid and captures fail_idx, fail_got and fail_exp. Later mismatches do not overwrite them.
- dut_mode and dut_code drive the latched configuration during the whole run, and 0 in IDLE.
- `start` while busy is ignored.
- Pointers wrap modulo 2^width with no error.

## Timing
- Reset value of all outputs is 0; the FSM resets to IDLE.
- Reset asserted mid-run aborts immediately: outputs return to 0 and the FSM to IDLE.
- `start` sampled at cycle t → dut_set = 1 in cycle t+1.
- Zero-latency data path: a word presented while dut_ready = 1 is consumed at that clock edge. The next word appears in the following cycle.
- Compares happen in the same cycle as dut_finish, with no pipeline.
- Multi-cycle finish: each high cycle is one result, including finish cycles that fall in GAP.
- First finish at cycle f → GAP occupies cycles f+1 … f+cfg_gap → the next dut_set is in cycle f+cfg_gap+1.
- busy = 1 in SET, RUN and GAP.
- done rises in the cycle after the last GAP cycle, or after a timeout.

## Structure
- Shared package `bch_pkg`:
  - code constants CODE_63 = 1, CODE_255 = 2, CODE_1023 = 3;
  - mode constants MODE_HARD = 0, MODE_SOFT = 1;
  - the FSM state enum;
  - default DATA_W and ODATA_W.
- One sub-module, `bch_pp_checker`: the compare logic, saturating err_cnt, cmp_cnt and first-fail capture. Its inputs are `en`, `finish`, `got`, `exp` and `clr`.
- The top level holds the FSM, the pointers, the gap counter and the watchdog.

## Test plan
- Golden behavioural DUT model, code = 1, hard mode, ntest = 4, gap = 10, all results matching → err_cnt = 0, fail_valid = 0, done = 1, exactly 4 set pulses, each 1 cycle wide.
- Soft mode, code = 3, model emits 3 finish cycles per decode, ntest = 2 → cmp_cnt = 6 and gold_addr ends at 6.
- Model corrupts result index 5 (odata = 0x155, golden 0x0AA) → err_cnt = 1, fail_idx = 5, fail_got = 0x155, fail_exp = 0x0AA.
- Model never asserts finish, cfg_timeout = 100 → timeout = 1 and done = 1 exactly 100 cycles after set; busy = 0.
- Model asserts ready for 8 consecutive cycles, then 3 cycles with gaps → stim_addr advances by exactly 11, and dut_idata matches memory words 0…10 in order.
- rst asserted mid-RUN; start pulsed while busy; cfg_ntest = 0:
  - all outputs 0 immediately after rst;
  - start while busy has no effect;
  - cfg_ntest = 0 gives done in the cycle after start with no set pulse.
